ethernet_tx: RTL and testbench

- RMII transmit MAC for the Ethernet IO block. It serialises one frame per start request onto TXD[1:0]/TX_EN as dibits, LSB first.
- Frame layout: preamble, SFD, destination MAC, source MAC (parameter), length/type, payload pulled byte-by-byte from an upstream first-word-fall-through FIFO, optional zero padding, FCS, then inter-packet gap.
- Sits beside the RMII receiver; shares ethernet_pkg and the CRC32 engine with it.

---
 rtl/ethernet_pkg.sv | 31 +++
 rtl/ethernet_crc32.sv | 41 ++++
 rtl/ethernet_tx.sv | 214 +++++++++++++++++++++
 tb/tb_ethernet_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_pkg.sv
// Shared Ethernet constants and the transmit state type.
// Build option: ETH_TX_AUTO_PAD_EN adds the PADDING state for runt frames.
package ethernet_pkg;

    localparam int unsigned PREAMBLE_BYTES    = 7;
    localparam int unsigned MAC_ADDR_BYTES    = 6;
    localparam int unsigned ETH_TYPE_BYTES    = 2;
    localparam int unsigned CRC_BYTES         = 4;
    localparam int unsigned IPG_BYTES         = 12;
    localparam int unsigned MIN_PAYLOAD_BYTES = 46;
    localparam int unsigned MAX_PAYLOAD_BYTES = 1500;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    typedef enum logic [3:0] {
        StIdle,
        StPreamble,
        StSfd,
        StMacDestination,
        StMacSource,
        StEthType,
        StPayload,
`ifdef ETH_TX_AUTO_PAD_EN
        StPadding,
`endif
        StFrameCheckSequence,
        StInterPacketGap
    } tx_state_e;

endpackage

// File: rtl/ethernet_crc32.sv
// Byte-wide Ethernet CRC32 (reflected 0xEDB88320, init all ones).
// crc32_o is the complemented remainder, i.e. the FCS ready to send low byte first.
module ethernet_crc32 (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        initialize_i,
    input  logic        compute_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc32_o
);

    localparam logic [31:0] POLY = 32'hEDB88320;

    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic        feedback;

    // Fold one byte into the remainder, LSB first
    always_comb begin
        crc_next = crc_q;
        feedback = 1'b0;
        for (int i = 0; i < 8; i++) begin
            feedback = crc_next[0] ^ data_i[i];
            crc_next = {1'b0, crc_next[31:1]} ^ (feedback ? POLY : 32'h0);
        end
    end

    // Remainder register; initialisation wins over computation
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= 32'hFFFF_FFFF;
        end else if (initialize_i) begin
            crc_q <= 32'hFFFF_FFFF;
        end else if (compute_i) begin
            crc_q <= crc_next;
        end
    end

    assign crc32_o = ~crc_q;

endmodule

// File: rtl/ethernet_tx.sv
// RMII transmit MAC: one frame per start request, dibits LSB first on sample_i ticks.
// Build option: ETH_TX_AUTO_PAD_EN zero-pads payloads shorter than 46 bytes.
module ethernet_tx
    import ethernet_pkg::*;
#(
    parameter logic [47:0] MAC_ADDRESS = 48'hFF_FF_FF_FF_FF_FF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            sample_i,
    input  logic            start_i,
    input  logic [5:0][7:0] destination_address_i,
    input  logic [1:0][7:0] length_type_i,
    input  logic [10:0]     payload_length_i,
    input  logic [7:0]      payload_i,
    input  logic            payload_valid_i,
    output logic            payload_ready_o,
    output logic [1:0]      rmii_txd_o,
    output logic            rmii_txen_o,
    output logic            idle_o,
    output logic            done_o,
    output logic            underrun_o
);

    localparam logic [5:0][7:0] MAC_BYTES = MAC_ADDRESS;

    tx_state_e       state_q;
    tx_state_e       next_state;
    tx_state_e       after_type;
    tx_state_e       after_payload;
    logic [1:0]      bit_counter_q;
    logic [10:0]     byte_counter_q;
    logic [10:0]     field_len;
    logic [5:0][7:0] dst_q;
    logic [1:0][7:0] lt_q;
    logic [10:0]     len_q;
    logic [7:0]      byte_q;
    logic [7:0]      cur_byte;
    logic [1:0]      txd_q;
    logic            txen_q;
    logic            idle_q;
    logic            done_q;
    logic            underrun_q;
    logic [31:0]     crc32;
    logic            first_dibit;
    logic            last_tick;
    logic            pop;
    logic            underrun_now;
    logic            crc_init;
    logic            crc_compute;

    assign first_dibit  = (bit_counter_q == 2'd0);
    assign last_tick    = (&bit_counter_q) && (byte_counter_q == field_len - 11'd1);
    assign pop          = sample_i && (state_q == StPayload) && first_dibit;
    assign underrun_now = pop && !payload_valid_i;
    assign crc_init     = (state_q == StIdle) && start_i;

    // Length of the field being sent, in bytes
    always_comb begin
        field_len = 11'd1;
        unique case (state_q)
            StPreamble:           field_len = 11'(PREAMBLE_BYTES);
            StSfd:                field_len = 11'd1;
            StMacDestination:     field_len = 11'(MAC_ADDR_BYTES);
            StMacSource:          field_len = 11'(MAC_ADDR_BYTES);
            StEthType:            field_len = 11'(ETH_TYPE_BYTES);
            StPayload:            field_len = len_q;
`ifdef ETH_TX_AUTO_PAD_EN
            StPadding:            field_len = 11'(MIN_PAYLOAD_BYTES) - len_q;
`endif
            StFrameCheckSequence: field_len = 11'(CRC_BYTES);
            StInterPacketGap:     field_len = 11'(IPG_BYTES);
            default:              field_len = 11'd1;
        endcase
    end

    // Field sequencing, with the optional pad stage after the payload
    always_comb begin
`ifdef ETH_TX_AUTO_PAD_EN
        after_payload = (len_q < 11'(MIN_PAYLOAD_BYTES)) ? StPadding : StFrameCheckSequence;
`else
        after_payload = StFrameCheckSequence;
`endif
        after_type = (len_q != 11'd0) ? StPayload : after_payload;
        next_state = StIdle;
        unique case (state_q)
            StPreamble:           next_state = StSfd;
            StSfd:                next_state = StMacDestination;
            StMacDestination:     next_state = StMacSource;
            StMacSource:          next_state = StEthType;
            StEthType:            next_state = after_type;
            StPayload:            next_state = after_payload;
`ifdef ETH_TX_AUTO_PAD_EN
            StPadding:            next_state = StFrameCheckSequence;
`endif
            StFrameCheckSequence: next_state = StInterPacketGap;
            default:              next_state = StIdle;
        endcase
    end

    // Byte to launch when its first dibit goes out; addresses go high byte first
    always_comb begin
        cur_byte = 8'h00;
        unique case (state_q)
            StPreamble:           cur_byte = PREAMBLE_BYTE;
            StSfd:                cur_byte = SFD_BYTE;
            StMacDestination:     cur_byte = dst_q[3'd5 - byte_counter_q[2:0]];
            StMacSource:          cur_byte = MAC_BYTES[3'd5 - byte_counter_q[2:0]];
            StEthType:            cur_byte = lt_q[~byte_counter_q[0]];
            StPayload:            cur_byte = payload_i;
            StFrameCheckSequence: cur_byte = crc32[{byte_counter_q[1:0], 3'b000} +: 8];
            default:              cur_byte = 8'h00;
        endcase
    end

    // CRC covers destination through payload/padding, once per byte
    always_comb begin
        crc_compute = 1'b0;
        if (sample_i && first_dibit) begin
            unique case (state_q)
                StMacDestination, StMacSource, StEthType: crc_compute = 1'b1;
`ifdef ETH_TX_AUTO_PAD_EN
                StPadding:                                crc_compute = 1'b1;
`endif
                StPayload:                                crc_compute = payload_valid_i;
                default:                                  crc_compute = 1'b0;
            endcase
        end
    end

    ethernet_crc32 u_crc32 (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .initialize_i (crc_init),
        .compute_i    (crc_compute),
        .data_i       (cur_byte),
        .crc32_o      (crc32)
    );

    // Transmit FSM, counters and registered line outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= StIdle;
            bit_counter_q  <= 2'd0;
            byte_counter_q <= 11'd0;
            dst_q          <= '0;
            lt_q           <= '0;
            len_q          <= 11'd0;
            byte_q         <= 8'h00;
            txd_q          <= 2'b00;
            txen_q         <= 1'b0;
            idle_q         <= 1'b1;
            done_q         <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
            if (state_q == StIdle) begin
                if (start_i) begin
                    dst_q          <= destination_address_i;
                    lt_q           <= length_type_i;
                    len_q          <= (payload_length_i > 11'(MAX_PAYLOAD_BYTES)) ?
                                      11'(MAX_PAYLOAD_BYTES) : payload_length_i;
                    bit_counter_q  <= 2'd0;
                    byte_counter_q <= 11'd0;
                    idle_q         <= 1'b0;
                    state_q        <= StPreamble;
                end
            end else if (sample_i) begin
                if (state_q == StInterPacketGap || underrun_now) begin
                    txen_q <= 1'b0;
                    txd_q  <= 2'b00;
                end else begin
                    txen_q <= 1'b1;
                    if (first_dibit) begin
                        txd_q  <= cur_byte[1:0];
                        byte_q <= cur_byte;
                    end else begin
                        txd_q <= byte_q[{bit_counter_q, 1'b0} +: 2];
                    end
                end

                if (underrun_now) begin
                    underrun_q     <= 1'b1;
                    bit_counter_q  <= 2'd0;
                    byte_counter_q <= 11'd0;
                    state_q        <= StInterPacketGap;
                end else if (last_tick) begin
                    bit_counter_q  <= 2'd0;
                    byte_counter_q <= 11'd0;
                    state_q        <= next_state;
                    if (state_q == StInterPacketGap) begin
                        done_q <= 1'b1;
                        idle_q <= 1'b1;
                    end
                end else begin
                    bit_counter_q <= bit_counter_q + 2'd1;
                    if (&bit_counter_q) begin
                        byte_counter_q <= byte_counter_q + 11'd1;
                    end
                end
            end
        end
    end

    // The pop is coincident with the capture so a FWFT FIFO advances in step
    assign payload_ready_o = pop && payload_valid_i;
    assign rmii_txd_o      = txd_q;
    assign rmii_txen_o     = txen_q;
    assign idle_o          = idle_q;
    assign done_o          = done_q;
    assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_ethernet_tx.sv
// Self-checking bench for ethernet_tx: random sample ticks and payloads against a
// frame-level model (byte list + bit-reversed MSB-first CRC32).
module tb_ethernet_tx;

    localparam logic [47:0] TB_MAC = 48'h02_12_34_56_78_9A;
    localparam logic [5:0][7:0] TB_MAC_BYTES = TB_MAC;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b1;
    logic            sample_i = 1'b0;
    logic            start_i = 1'b0;
    logic [5:0][7:0] destination_address_i = '0;
    logic [1:0][7:0] length_type_i = '0;
    logic [10:0]     payload_length_i = '0;
    logic [7:0]      payload_i = '0;
    logic            payload_valid_i = 1'b0;
    logic            payload_ready_o;
    logic [1:0]      rmii_txd_o;
    logic            rmii_txen_o;
    logic            idle_o;
    logic            done_o;
    logic            underrun_o;

    ethernet_tx #(.MAC_ADDRESS(TB_MAC)) dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .sample_i              (sample_i),
        .start_i               (start_i),
        .destination_address_i (destination_address_i),
        .length_type_i         (length_type_i),
        .payload_length_i      (payload_length_i),
        .payload_i             (payload_i),
        .payload_valid_i       (payload_valid_i),
        .payload_ready_o       (payload_ready_o),
        .rmii_txd_o            (rmii_txd_o),
        .rmii_txen_o           (rmii_txen_o),
        .idle_o                (idle_o),
        .done_o                (done_o),
        .underrun_o            (underrun_o)
    );

    always #5 clk_i = ~clk_i;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] fifo_mem [0:2047];
    int         fifo_idx = 0;
    int         drop_at = -1;
    int         pop_count = 0;
    int         done_total = 0;
    int         und_total = 0;
    bit         done_seen = 1'b0;
    int         idx_start = 0;
    int         exp_pops = 0;
    logic [4:0] line_q [$];   // {done, underrun, txen, txd} per sample tick
    logic [7:0] exp_q [$];

    // Upstream FIFO model, random sample ticks, and per-tick line capture
    always begin : drive_and_monitor
        bit pre_sample;
        bit pre_ready;
        @(negedge clk_i);
        sample_i        = ($urandom_range(0, 2) != 0);
        payload_i       = fifo_mem[fifo_idx[10:0]];
        payload_valid_i = (fifo_idx != drop_at);
        #4;
        pre_sample = sample_i;
        pre_ready  = payload_ready_o;
        @(posedge clk_i);
        #1;
        if (pre_ready) begin
            pop_count++;
            fifo_idx++;
        end
        if (pre_sample) line_q.push_back({done_o, underrun_o, rmii_txen_o, rmii_txd_o});
        if (done_o) begin
            done_total++;
            done_seen = 1'b1;
        end
        if (underrun_o) und_total++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        for (int i = 0; i < 32; i++) rev32[i] = v[31-i];
    endfunction

    // Textbook CRC32 (poly 0x04C11DB7, MSB first) over destination..payload/pad
    function automatic logic [31:0] crc_ref();
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int k = 8; k < exp_q.size(); k++) begin
            c = c ^ {rev8(exp_q[k]), 24'h0};
            for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
        end
        return ~rev32(c);
    endfunction

    task automatic setup_frame(input logic [5:0][7:0] dst, input logic [15:0] lt,
                               input int len, input int drop, input bit seq);
        int          plen;
        int          npay;
        logic [31:0] fcs;
        @(negedge clk_i);
        #2;
        destination_address_i = dst;
        length_type_i         = lt;
        payload_length_i      = 11'(len);
        for (int i = 0; i < 2048; i++) fifo_mem[i] = seq ? 8'(i) : 8'($urandom);
        fifo_idx   = 0;
        pop_count  = 0;
        drop_at    = drop;
        done_total = 0;
        und_total  = 0;
        done_seen  = 1'b0;
        line_q.delete();
        exp_q.delete();
        plen = (len > 1500) ? 1500 : len;
        npay = (drop >= 0) ? drop : plen;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) exp_q.push_back(dst[5-i]);
        for (int i = 0; i < 6; i++) exp_q.push_back(TB_MAC_BYTES[5-i]);
        exp_q.push_back(lt[15:8]);
        exp_q.push_back(lt[7:0]);
        for (int i = 0; i < npay; i++) exp_q.push_back(fifo_mem[i]);
        if (drop < 0) begin
`ifdef ETH_TX_AUTO_PAD_EN
            for (int i = plen; i < 46; i++) exp_q.push_back(8'h00);
`endif
            fcs = crc_ref();
            for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
        end
        exp_pops = npay;
    endtask

    task automatic start_frame();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i   = 1'b0;
        idx_start = line_q.size();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_i);
            if (done_seen) break;
        end
        chk("done_within_budget", done_seen, 1);
        chk("idle_after_done", idle_o, 1);
    endtask

    task automatic analyze(input bit exp_und);
        int         f = -1;
        int         n = 0;
        int         bad_idx = -1;
        int         dpos = -1;
        int         upos = -1;
        int         gap_bad = 0;
        logic [7:0] b;
        for (int i = 0; i < line_q.size(); i++) begin
            if (line_q[i][2] && f < 0) f = i;
            if (line_q[i][4]) dpos = i;
            if (line_q[i][3]) upos = i;
        end
        chk("txen_rise_tick", f, idx_start);
        if (f >= 0) while (f + n < line_q.size() && line_q[f+n][2]) n++;
        chk("frame_ticks", n, 4 * exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (4*k + 3 < n) begin
                b = {line_q[f+4*k+3][1:0], line_q[f+4*k+2][1:0],
                     line_q[f+4*k+1][1:0], line_q[f+4*k][1:0]};
                if (b !== exp_q[k] && bad_idx < 0) bad_idx = k;
            end
        end
        chk("first_bad_byte_index", bad_idx, -1);
        if (f >= 0) for (int i = f + n; i <= dpos; i++) if (line_q[i][2:0] != 3'b000) gap_bad++;
        chk("ipg_line_quiet", gap_bad, 0);
        chk("done_count", done_total, 1);
        chk("done_tick", dpos, f + n + 47 + int'(exp_und));
        chk("underrun_count", und_total, int'(exp_und));
        if (exp_und) chk("underrun_tick", upos, f + n);
        chk("ready_pulses", pop_count, exp_pops);
    endtask

    task automatic run_frame(input logic [5:0][7:0] dst, input logic [15:0] lt,
                             input int len, input int drop, input bit seq);
        setup_frame(dst, lt, len, drop, seq);
        start_frame();
        wait_done();
        analyze(drop >= 0);
    endtask

    initial begin : main
        logic [5:0][7:0] rdst;
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_txd", rmii_txd_o, 2'b00);
        chk("rst_txen", rmii_txen_o, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_ready", payload_ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_underrun", underrun_o, 0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;

        // Reference frame: 60 sequential bytes to broadcast, IPv4 type, stray start mid-frame
        setup_frame({6{8'hFF}}, 16'h0800, 60, -1, 1'b1);
        start_frame();
        repeat (100) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done();
        analyze(1'b0);
        chk("preamble_dibit0", line_q[idx_start][1:0], 2'b01);
        chk("preamble_dibit3", line_q[idx_start+3][1:0], 2'b01);
        chk("sfd_dibit0", line_q[idx_start+28][1:0], 2'b01);
        chk("sfd_dibit3", line_q[idx_start+31][1:0], 2'b11);

        // Short payload (padded or not depending on build), then empty payload
        rdst = {$urandom, $urandom};
        run_frame(rdst, 16'(($urandom)), 10, -1, 1'b0);
        run_frame(rdst, 16'h88B5, 0, -1, 1'b0);

        // Underrun at payload byte 5 of 20
        run_frame({$urandom, $urandom}, 16'h0014, 20, 5, 1'b0);

        // Oversized request is clamped to the maximum payload
        run_frame({$urandom, $urandom}, 16'h86DD, 2000, -1, 1'b0);

        // Random length frame
        run_frame({$urandom, $urandom}, 16'(($urandom)), $urandom_range(1, 120), -1, 1'b0);

        // Asynchronous reset while the source address is on the line
        setup_frame({$urandom, $urandom}, 16'h0800, 30, -1, 1'b0);
        start_frame();
        for (int i = 0; i < 5000 && line_q.size() < idx_start + 68; i++) @(negedge clk_i);
        chk("reached_source_field", line_q.size() >= idx_start + 68, 1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("midrst_txen", rmii_txen_o, 0);
        chk("midrst_txd", rmii_txd_o, 2'b00);
        chk("midrst_idle", idle_o, 1);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        run_frame({$urandom, $urandom}, 16'h0806, 64, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
